// File: rtl/hssl_apb_requester.sv
`default_nettype none
// ============================================================================
// Module   : hssl_apb_requester
// Brief    : Single-outstanding APB3 requester with response channel and
//            ACCESS-phase stall timeout.
// Revision : 1.0
// ============================================================================
module hssl_apb_requester #(
  parameter int unsigned ADDR_BITS      = 40,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] req_addr_in,
  input  logic [31:0]          req_wdata_in,
  input  logic                 req_write_in,
  input  logic                 req_vld_in,
  output logic                 req_rdy_out,
  output logic [31:0]          rsp_rdata_out,
  output logic                 rsp_err_out,
  output logic                 rsp_vld_out,
  input  logic                 rsp_rdy_in,
  output logic                 apb_psel_out,
  output logic                 apb_penable_out,
  output logic                 apb_pwrite_out,
  output logic [ADDR_BITS-1:0] apb_paddr_out,
  output logic [31:0]          apb_pwdata_out,
  input  logic [31:0]          apb_prdata_in,
  input  logic                 apb_pready_in,
  input  logic                 apb_pslverr_in,
  output logic [15:0]          tmo_ctr_out
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_SETUP  = 2'd1;
  localparam logic [1:0]  S_ACCESS = 2'd2;
  localparam logic [1:0]  S_RESP   = 2'd3;
  localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam logic        c_TMO_EN   = (TIMEOUT_CYCLES != 0);

  logic [1:0]           r_state, w_state_nxt;
  logic [31:0]          r_wait_cnt, w_wait_cnt;
  logic                 r_req_rdy, w_req_rdy;
  logic [31:0]          r_rsp_rdata, w_rsp_rdata;
  logic                 r_rsp_err, w_rsp_err;
  logic                 r_rsp_vld, w_rsp_vld;
  logic                 r_psel, w_psel;
  logic                 r_penable, w_penable;
  logic                 r_pwrite, w_pwrite;
  logic [ADDR_BITS-1:0] r_paddr, w_paddr;
  logic [31:0]          r_pwdata, w_pwdata;
  logic [15:0]          r_tmo_ctr, w_tmo_ctr;
  logic                 w_tmo_hit;

  // Counter holds the number of completed low-pready ACCESS cycles, so the
  // abort fires on the edge that ends the TIMEOUT_CYCLES-th one.
  assign w_tmo_hit = c_TMO_EN && (r_wait_cnt == c_TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_req_rdy   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_vld   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_tmo_ctr   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt;
      r_req_rdy   <= w_req_rdy;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
      r_rsp_vld   <= w_rsp_vld;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_tmo_ctr   <= w_tmo_ctr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_req_rdy && req_vld_in) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (apb_pready_in || w_tmo_hit) w_state_nxt = S_RESP;
      S_RESP:   if (rsp_rdy_in) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wait_cnt  = r_wait_cnt;
    w_req_rdy   = (w_state_nxt == S_IDLE);
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = r_rsp_err;
    w_rsp_vld   = r_rsp_vld;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_tmo_ctr   = r_tmo_ctr;
    case (r_state)
      S_IDLE: begin
        if (r_req_rdy && req_vld_in) begin
          w_paddr   = req_addr_in;
          w_pwdata  = req_wdata_in;
          w_pwrite  = req_write_in;
          w_psel    = 1'b1;
          w_penable = 1'b0;
        end
      end
      S_SETUP: begin
        w_penable  = 1'b1;
        w_wait_cnt = '0;
      end
      S_ACCESS: begin
        if (apb_pready_in) begin
          w_rsp_rdata = r_pwrite ? 32'd0 : apb_prdata_in;
          w_rsp_err   = apb_pslverr_in;
          w_rsp_vld   = 1'b1;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
        end else if (w_tmo_hit) begin
          w_rsp_rdata = 32'hdead_beef;
          w_rsp_err   = 1'b1;
          w_rsp_vld   = 1'b1;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          if (r_tmo_ctr != 16'hffff) w_tmo_ctr = r_tmo_ctr + 16'd1;
        end else begin
          w_wait_cnt = r_wait_cnt + 32'd1;
        end
      end
      S_RESP: begin
        if (rsp_rdy_in) w_rsp_vld = 1'b0;
      end
      default: ;
    endcase
  end

  assign req_rdy_out     = r_req_rdy;
  assign rsp_rdata_out   = r_rsp_rdata;
  assign rsp_err_out     = r_rsp_err;
  assign rsp_vld_out     = r_rsp_vld;
  assign apb_psel_out    = r_psel;
  assign apb_penable_out = r_penable;
  assign apb_pwrite_out  = r_pwrite;
  assign apb_paddr_out   = r_paddr;
  assign apb_pwdata_out  = r_pwdata;
  assign tmo_ctr_out     = r_tmo_ctr;

endmodule
`default_nettype wire

// File: tb/tb_hssl_apb_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_hssl_apb_requester
// Brief    : Transaction-level bench for hssl_apb_requester.
// Revision : 1.0
// ============================================================================
module tb_hssl_apb_requester;

  localparam int unsigned AW  = 40;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] req_addr_in;
  logic [31:0]   req_wdata_in;
  logic          req_write_in;
  logic          req_vld_in;
  logic          req_rdy_out;
  logic [31:0]   rsp_rdata_out;
  logic          rsp_err_out;
  logic          rsp_vld_out;
  logic          rsp_rdy_in;
  logic          apb_psel_out;
  logic          apb_penable_out;
  logic          apb_pwrite_out;
  logic [AW-1:0] apb_paddr_out;
  logic [31:0]   apb_pwdata_out;
  logic [31:0]   apb_prdata_in;
  logic          apb_pready_in;
  logic          apb_pslverr_in;
  logic [15:0]   tmo_ctr_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_tmo    = 16'd0;

  always #5 clk = ~clk;

  hssl_apb_requester #(.ADDR_BITS(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
    .req_write_in(req_write_in), .req_vld_in(req_vld_in), .req_rdy_out(req_rdy_out),
    .rsp_rdata_out(rsp_rdata_out), .rsp_err_out(rsp_err_out),
    .rsp_vld_out(rsp_vld_out), .rsp_rdy_in(rsp_rdy_in),
    .apb_psel_out(apb_psel_out), .apb_penable_out(apb_penable_out),
    .apb_pwrite_out(apb_pwrite_out), .apb_paddr_out(apb_paddr_out),
    .apb_pwdata_out(apb_pwdata_out), .apb_prdata_in(apb_prdata_in),
    .apb_pready_in(apb_pready_in), .apb_pslverr_in(apb_pslverr_in),
    .tmo_ctr_out(tmo_ctr_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request/response; expected response derived from the transfer
  // description (completer wait count, error, data) and the timeout rule.
  task automatic do_xfer(input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic wr, input int waits, input logic serr,
                         input logic [31:0] rdat, input int rdly);
    logic        tmo;
    logic [31:0] e_rdata;
    logic        e_err;
    bit          done;
    int          n;
    n = 0;
    while (req_rdy_out !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_rdy_idle", 64'(req_rdy_out), 64'd1);
    req_addr_in  = addr;
    req_wdata_in = wdata;
    req_write_in = wr;
    req_vld_in   = 1'b1;
    tick();
    chk("setup_psel", 64'(apb_psel_out), 64'd1);
    chk("setup_penable", 64'(apb_penable_out), 64'd0);
    chk("setup_paddr", 64'(apb_paddr_out), 64'(addr));
    chk("setup_pwdata", 64'(apb_pwdata_out), 64'(wdata));
    chk("setup_pwrite", 64'(apb_pwrite_out), 64'(wr));
    chk("setup_req_rdy", 64'(req_rdy_out), 64'd0);
    req_vld_in    = 1'($urandom_range(0, 1));
    req_addr_in   = ~addr;
    req_wdata_in  = ~wdata;
    req_write_in  = ~wr;
    apb_pready_in = 1'b0;
    tick();
    chk("access_penable", 64'(apb_penable_out), 64'd1);
    chk("access_psel", 64'(apb_psel_out), 64'd1);
    chk("access_paddr", 64'(apb_paddr_out), 64'(addr));
    chk("access_pwdata", 64'(apb_pwdata_out), 64'(wdata));
    chk("access_pwrite", 64'(apb_pwrite_out), 64'(wr));
    tmo  = (waits >= int'(TMO));
    done = 1'b0;
    for (int k = 0; !done; k++) begin
      apb_pready_in  = (k == waits);
      apb_prdata_in  = (k == waits) ? rdat : $urandom;
      apb_pslverr_in = (k == waits) ? serr : 1'($urandom_range(0, 1));
      tick();
      done = (k == waits) || (tmo && k == int'(TMO) - 1);
      if (!done) begin
        chk("wait_psel", 64'(apb_psel_out), 64'd1);
        chk("wait_penable", 64'(apb_penable_out), 64'd1);
        chk("wait_rsp_vld", 64'(rsp_vld_out), 64'd0);
      end
    end
    apb_pready_in  = 1'b0;
    apb_pslverr_in = 1'b0;
    if (tmo) begin
      e_rdata = 32'hdead_beef;
      e_err   = 1'b1;
      if (m_tmo != 16'hffff) m_tmo = m_tmo + 16'd1;
    end else begin
      e_rdata = wr ? 32'd0 : rdat;
      e_err   = serr;
    end
    chk("rsp_vld", 64'(rsp_vld_out), 64'd1);
    chk("rsp_psel_drop", 64'(apb_psel_out), 64'd0);
    chk("rsp_penable_drop", 64'(apb_penable_out), 64'd0);
    chk("rsp_rdata", 64'(rsp_rdata_out), 64'(e_rdata));
    chk("rsp_err", 64'(rsp_err_out), 64'(e_err));
    chk("tmo_ctr", 64'(tmo_ctr_out), 64'(m_tmo));
    chk("rsp_req_rdy", 64'(req_rdy_out), 64'd0);
    chk("rsp_paddr_kept", 64'(apb_paddr_out), 64'(addr));
    for (int d = 0; d < rdly; d++) begin
      rsp_rdy_in = 1'b0;
      req_vld_in = 1'b1;
      tick();
      chk("bp_rsp_vld", 64'(rsp_vld_out), 64'd1);
      chk("bp_rdata", 64'(rsp_rdata_out), 64'(e_rdata));
      chk("bp_err", 64'(rsp_err_out), 64'(e_err));
      chk("bp_req_rdy", 64'(req_rdy_out), 64'd0);
      chk("bp_psel", 64'(apb_psel_out), 64'd0);
    end
    rsp_rdy_in = 1'b1;
    req_vld_in = 1'b1;
    tick();
    chk("hs_rsp_vld", 64'(rsp_vld_out), 64'd0);
    chk("hs_req_rdy", 64'(req_rdy_out), 64'd1);
    chk("hs_no_accept", 64'(apb_psel_out), 64'd0);
    req_vld_in = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    req_addr_in    = '0;
    req_wdata_in   = '0;
    req_write_in   = 1'b0;
    req_vld_in     = 1'b0;
    rsp_rdy_in     = 1'b1;
    apb_prdata_in  = '0;
    apb_pready_in  = 1'b0;
    apb_pslverr_in = 1'b0;
    tick();
    tick();
    chk("rst_req_rdy", 64'(req_rdy_out), 64'd0);
    chk("rst_psel", 64'(apb_psel_out), 64'd0);
    chk("rst_penable", 64'(apb_penable_out), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld_out), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata_out), 64'd0);
    chk("rst_err", 64'(rsp_err_out), 64'd0);
    chk("rst_paddr", 64'(apb_paddr_out), 64'd0);
    chk("rst_tmo", 64'(tmo_ctr_out), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_req_rdy", 64'(req_rdy_out), 64'd1);

    do_xfer(40'h08, 32'h1234_5678, 1'b1, 0, 1'b0, 32'h0, 0);
    do_xfer(40'h10, 32'h5555_aaaa, 1'b0, 3, 1'b0, 32'hffff_fd00, 0);
    do_xfer(40'h20, 32'h0, 1'b0, 1, 1'b1, 32'h0bad_0bad, 0);
    do_xfer(40'h24, 32'hcafe_f00d, 1'b1, 0, 1'b0, 32'h0, 0);
    for (int t = 0; t < 4; t++)
      do_xfer(40'h30 + 40'(t), $urandom, 1'($urandom_range(0, 1)), 8 + 4 * t, 1'b0, 32'h0, 0);
    do_xfer(40'h40, 32'h0, 1'b0, 7, 1'b0, 32'h7777_0007, 0);
    do_xfer(40'h44, 32'h0, 1'b0, 1, 1'b0, 32'h4444_4444, 5);

    for (int r = 0; r < 30; r++) begin
      logic [AW-1:0] ra;
      int            rw;
      ra = {8'($urandom), 32'($urandom)};
      rw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 7));
      do_xfer(ra, $urandom, 1'($urandom_range(0, 1)), rw, 1'($urandom_range(0, 1)),
              $urandom, int'($urandom_range(0, 3)));
    end

    // Reset while the transfer sits in ACCESS with a stalled completer.
    req_addr_in  = 40'h50;
    req_wdata_in = 32'h1;
    req_write_in = 1'b1;
    req_vld_in   = 1'b1;
    tick();
    req_vld_in    = 1'b0;
    apb_pready_in = 1'b0;
    tick();
    tick();
    chk("mid_in_access", 64'(apb_penable_out), 64'd1);
    reset = 1'b1;
    tick();
    m_tmo = 16'd0;
    chk("mid_rst_psel", 64'(apb_psel_out), 64'd0);
    chk("mid_rst_penable", 64'(apb_penable_out), 64'd0);
    chk("mid_rst_rsp_vld", 64'(rsp_vld_out), 64'd0);
    chk("mid_rst_tmo", 64'(tmo_ctr_out), 64'(m_tmo));
    reset = 1'b0;
    tick();
    chk("mid_rst_req_rdy", 64'(req_rdy_out), 64'd1);
    do_xfer(40'h60, 32'h0, 1'b0, 2, 1'b0, 32'h6060_6060, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hssl_apb_requester.md
# hssl_apb_requester

APB requester (initiator) that turns single register-access requests into complete APB3 transfers on the configuration bus. It sits between a command source (host packet decoder or test controller) and the `hssl_reg_bank`-style completers, issuing one setup/access sequence per request. It returns read data and error status on a response channel, and aborts transfers that stall.

## Interface

Parameters:
- `ADDR_BITS`, 40, APB address width.
- `TIMEOUT_CYCLES`, 64, max ACCESS cycles without `pready`; 0 disables timeout.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_addr_in`  in  ADDR_BITS  request byte address.
- `req_wdata_in`  in  32  request write data.
- `req_write_in`  in  1  1 = write, 0 = read.
- `req_vld_in`  in  1  request valid.
- `req_rdy_out`  out  1  request ready.
- `rsp_rdata_out`  out  32  read data; 0 for writes; `32'hdead_beef` on timeout.
- `rsp_err_out`  out  1  `pslverr` captured, or timeout.
- `rsp_vld_out`  out  1  response valid.
- `rsp_rdy_in`  in  1  response ready.
- `apb_psel_out`  out  1  APB select.
- `apb_penable_out`  out  1  APB enable.
- `apb_pwrite_out`  out  1  APB direction.
- `apb_paddr_out`  out  ADDR_BITS  APB address.
- `apb_pwdata_out`  out  32  APB write data.
- `apb_prdata_in`  in  32  APB read data.
- `apb_pready_in`  in  1  APB ready.
- `apb_pslverr_in`  in  1  APB slave error.
- `tmo_ctr_out`  out  16  saturating count of timed-out transfers.

## Operation

- FSM states are IDLE, SETUP, ACCESS and RESP. All outputs are registered.
- **IDLE**:
  - `req_rdy_out`=1.
  - When `req_vld_in`: latch addr/wdata/write into `apb_paddr_out`/`apb_pwdata_out`/`apb_pwrite_out`, set `psel`=1, `penable`=0, go to SETUP.
- **SETUP**: lasts exactly one cycle. Set `penable`=1, clear the timeout counter, go to ACCESS.
- **ACCESS**:
  - `psel`=`penable`=1. `paddr`/`pwdata`/`pwrite` are held stable.
  - When `apb_pready_in`=1: capture `rsp_rdata_out` (`apb_prdata_in` if read, else 0) and `rsp_err_out`=`apb_pslverr_in`; drop `psel`/`penable`; go to RESP.
  - When `pready`=0: increment the timeout counter.
  - When the counter reaches `TIMEOUT_CYCLES` (and `TIMEOUT_CYCLES`≠0): abort. Drop `psel`/`penable`, set `rsp_rdata_out`=`32'hdead_beef`, `rsp_err_out`=1, increment `tmo_ctr_out` (saturating at `16'hffff`), go to RESP.
- **RESP**:
  - `rsp_vld_out`=1. Response fields are held until `rsp_rdy_in`.
  - On handshake: `rsp_vld_out`=0, go to IDLE.
- `req_rdy_out`=0 in SETUP, ACCESS and RESP. Only one transfer is outstanding, with no pipelining.
- `paddr`/`pwdata`/`pwrite` keep their last values after a transfer. `pwdata` is driven for reads too (don't care).
- The address is passed unmodified. Byte/word mapping is the completer's concern.

## Timing

- Reset values: `req_rdy_out`=0 during reset, 1 in the first cycle after reset. All other outputs 0, `tmo_ctr_out`=0. State = IDLE.
- Request accepted at edge N (IDLE, `vld`&`rdy`):
  - `psel`=1 from N.
  - `penable`=1 from N+1.
  - With `pready`=1 in the first ACCESS cycle, `psel`/`penable`=0 and `rsp_vld_out`=1 from N+2.
- Minimum request-to-request period is 4 cycles with zero-wait completer and `rsp_rdy_in` held high.
- Each `pready` low cycle in ACCESS adds one cycle.
- A timeout fires after exactly `TIMEOUT_CYCLES` ACCESS cycles with `pready` low. `pready` arriving in the cycle the count reaches the limit wins: the transfer completes normally.
- `pslverr` is sampled only when `psel`&`penable`&`pready`.
- Reset asserted mid-transfer: next cycle IDLE with all outputs at reset values, so `psel`/`penable` drop immediately. The pending response is discarded. `tmo_ctr_out` clears.
- `rsp_rdy_in` may be held high permanently. `req_vld_in` asserted outside IDLE is ignored, with no latching.

## Test plan

- **Write.** Zero-wait completer, request write `addr=0x08`, `wdata=0x1234_5678`. Expect:
  - `psel` rises 1 cycle after the handshake, `penable` the cycle after.
  - `paddr=0x08`, `pwdata=0x1234_5678`, `pwrite=1` stable across both phases.
  - Response `rdata=0`, `err=0`.
- **Read with wait states.** Completer inserts 3 wait states, returns `0xffff_fd00`. Expect:
  - ACCESS lasts 4 cycles.
  - `rsp_rdata_out=0xffff_fd00`, `err=0`, `rsp_vld_out` 1 cycle after `pready`.
- **Slave error.** Completer returns `pslverr=1` with `pready`. Expect `rsp_err_out=1`, and the next request is accepted normally.
- **Timeout.** `TIMEOUT_CYCLES=8`, `pready` stuck low. Expect:
  - Abort after 8 ACCESS cycles; `rdata=0xdead_beef`, `err=1`, `tmo_ctr_out=1`.
  - Repeating 3 more times gives `tmo_ctr_out=4`.
  - `pready` rising on the 8th cycle completes normally, with no counter increment.
- **Response backpressure.** `rsp_rdy_in` held low 5 cycles after a read. Expect:
  - `rsp_vld_out` and data held stable, `req_rdy_out`=0 throughout.
  - A new `req_vld_in` is not accepted until the cycle after the handshake.
- **Reset mid-transfer.** Assert `reset` in ACCESS. Expect:
  - Next cycle `psel`=`penable`=`rsp_vld_out`=0, `tmo_ctr_out`=0.
  - `req_rdy_out`=1 one cycle after reset deasserts.
